css_line_feeder: RTL and testbench

- Upstream feeder for the 3x3 column shift structure (CSS).
- Accepts a raster-order pixel stream through a valid/ready handshake and keeps the two previous feature-map rows in on-chip line buffers.
- Drives CSS row_1/row_2/row_3 plus its LE/shift strobes, and reports when the CSS outputs hold a complete 3x3 window and where that window is centred.

---
 rtl/css_pkg.sv | 24 ++
 rtl/css_line_buffer.sv | 28 ++
 rtl/css_line_feeder.sv | 139 +++++++++++++
 tb/tb_css_line_feeder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/css_pkg.sv
// Shared types for the CSS line feeder: FSM encoding and the output-stage record.
package css_pkg;

  localparam int unsigned KERNEL_SIZE = 3;
  localparam int unsigned MAX_PIX_W   = 64;
  localparam int unsigned MAX_COORD_W = 16;

  typedef enum logic {
    STREAM = 1'b0,
    FLUSH  = 1'b1
  } feeder_state_t;

  // One output-stage entry; win/col/row/last describe the window completed by its shift.
  typedef struct packed {
    logic                                      le;
    logic                                      shift;
    logic                                      win;
    logic [KERNEL_SIZE-1:0][MAX_PIX_W-1:0]     rows;
    logic [MAX_COORD_W-1:0]                    col;
    logic [MAX_COORD_W-1:0]                    row;
    logic                                      last;
  } css_stage_t;

endpackage

// File: rtl/css_line_buffer.sv
// Two chained row buffers: lb_a holds row y-1, lb_b holds row y-2; read-first at addr.
module css_line_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] lb_a [DEPTH];
  logic [DATA_W-1:0] lb_b [DEPTH];

  assign rd_a = lb_a[addr];
  assign rd_b = lb_b[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb_b[addr] <= lb_a[addr];
      lb_a[addr] <= din;
    end
  end

endmodule

// File: rtl/css_line_feeder.sv
// Raster-stream feeder for the 3x3 column shift structure: line buffering,
// LE/shift strobe generation and window position tracking.
module css_line_feeder
  import css_pkg::*;
#(
  parameter int unsigned IO_DATA_WIDTH      = 16,
  parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
  parameter int unsigned FEATURE_MAP_HEIGHT = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_in,
  input  logic [IO_DATA_WIDTH-1:0]              pix_in,
  input  logic                                  pix_valid,
  output logic                                  pix_ready,
  input  logic                                  stall,
  output logic [IO_DATA_WIDTH-1:0]              row_1,
  output logic [IO_DATA_WIDTH-1:0]              row_2,
  output logic [IO_DATA_WIDTH-1:0]              row_3,
  output logic                                  LE,
  output logic                                  shift,
  output logic                                  win_valid,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  win_col,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] win_row,
  output logic                                  frame_done
);

  localparam int unsigned CW = $clog2(FEATURE_MAP_WIDTH);
  localparam int unsigned RW = $clog2(FEATURE_MAP_HEIGHT);

  feeder_state_t state, state_n;
  logic [CW-1:0] x_cnt;
  logic [RW-1:0] y_cnt;
  logic          x_last, y_last, accept;

  logic [IO_DATA_WIDTH-1:0] lb_a_rd, lb_b_rd;

  css_stage_t stg, stg_n;

  logic          win_q, fd_q;
  logic [CW-1:0] win_col_q;
  logic [RW-1:0] win_row_q;

  assign x_last = (x_cnt == CW'(FEATURE_MAP_WIDTH - 1));
  assign y_last = (y_cnt == RW'(FEATURE_MAP_HEIGHT - 1));
  assign accept = pix_valid && pix_ready;

  css_line_buffer #(
    .DATA_W (IO_DATA_WIDTH),
    .DEPTH  (FEATURE_MAP_WIDTH)
  ) u_line_buffer (
    .clk   (clk),
    .wr_en (accept),
    .addr  (x_cnt),
    .din   (pix_in),
    .rd_a  (lb_a_rd),
    .rd_b  (lb_b_rd)
  );

  always_ff @(posedge clk) begin
    if (rst_in) state <= STREAM;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      STREAM: if (accept && x_last) state_n = FLUSH;
      FLUSH:  if (!stall)           state_n = STREAM;
      default:                      state_n = STREAM;
    endcase
  end

  always_comb begin
    pix_ready = (state == STREAM) && !stall && !rst_in;
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (accept) x_cnt <= x_last ? '0 : x_cnt + 1'b1;
      if (state == FLUSH && !stall) y_cnt <= y_last ? '0 : y_cnt + 1'b1;
    end
  end

  // The shift issued with column x moves column x-1 into o_x_2; the FLUSH bubble moves W-1.
  always_comb begin
    stg_n       = stg;
    stg_n.le    = 1'b0;
    stg_n.shift = 1'b0;
    stg_n.win   = 1'b0;
    stg_n.last  = 1'b0;
    if (accept) begin
      stg_n.le      = 1'b1;
      stg_n.shift   = (x_cnt != '0);
      stg_n.rows[2] = MAX_PIX_W'(pix_in);
      stg_n.rows[1] = MAX_PIX_W'(lb_a_rd);
      stg_n.rows[0] = MAX_PIX_W'(lb_b_rd);
      stg_n.win     = (x_cnt >= CW'(3)) && (y_cnt >= RW'(2));
      stg_n.col     = MAX_COORD_W'(x_cnt - CW'(2));
      stg_n.row     = MAX_COORD_W'(y_cnt - RW'(1));
    end else if (state == FLUSH) begin
      stg_n.shift = 1'b1;
      stg_n.win   = (y_cnt >= RW'(2));
      stg_n.col   = MAX_COORD_W'(FEATURE_MAP_WIDTH - 2);
      stg_n.row   = MAX_COORD_W'(y_cnt - RW'(1));
      stg_n.last  = y_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      stg       <= '0;
      win_q     <= 1'b0;
      fd_q      <= 1'b0;
      win_col_q <= '0;
      win_row_q <= '0;
    end else if (!stall) begin
      stg       <= stg_n;
      win_q     <= stg.win;
      fd_q      <= stg.win && stg.last;
      win_col_q <= stg.col[CW-1:0];
      win_row_q <= stg.row[RW-1:0];
    end
  end

  // Stall masks the strobes while the stage holds; the held entry shows once stall drops.
  assign row_1      = stg.rows[0][IO_DATA_WIDTH-1:0];
  assign row_2      = stg.rows[1][IO_DATA_WIDTH-1:0];
  assign row_3      = stg.rows[2][IO_DATA_WIDTH-1:0];
  assign LE         = stg.le && !stall;
  assign shift      = stg.shift && !stall;
  assign win_valid  = win_q && !stall;
  assign frame_done = fd_q && !stall;
  assign win_col    = win_col_q;
  assign win_row    = win_row_q;

endmodule

// File: tb/tb_css_line_feeder.sv
// Scoreboard bench for css_line_feeder with W=5, H=4 and pixel value 16*y+x.
module tb_css_line_feeder;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_in;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic          stall;
  logic [DW-1:0] row_1, row_2, row_3;
  logic          LE, shift, win_valid, frame_done;
  logic [2:0]    win_col;
  logic [1:0]    win_row;

  css_line_feeder #(
    .IO_DATA_WIDTH      (DW),
    .FEATURE_MAP_WIDTH  (W),
    .FEATURE_MAP_HEIGHT (H)
  ) dut (
    .clk        (clk),
    .rst_in     (rst_in),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .stall      (stall),
    .row_1      (row_1),
    .row_2      (row_2),
    .row_3      (row_3),
    .LE         (LE),
    .shift      (shift),
    .win_valid  (win_valid),
    .win_col    (win_col),
    .win_row    (win_row),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            x;
    int            y;
    logic          sh;
    logic [DW-1:0] r1, r2, r3;
  } le_exp_t;

  typedef struct {
    int   col;
    int   row;
    logic last;
  } win_exp_t;

  le_exp_t  le_q[$];
  win_exp_t win_q[$];
  le_exp_t  le_e;
  win_exp_t win_e;

  int checks = 0;
  int errors = 0;
  int win_count = 0;
  int fd_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents LE or win_valid.
  always @(negedge clk) begin
    if (LE) begin
      if (le_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL le_unexpected: LE=1 with no pending pixel, row_3=0x%0h", row_3);
      end else begin
        le_e = le_q.pop_front();
        chk($sformatf("shift(%0d,%0d)", le_e.x, le_e.y), 64'(shift), 64'(le_e.sh));
        chk($sformatf("row_3(%0d,%0d)", le_e.x, le_e.y), 64'(row_3), 64'(le_e.r3));
        if (le_e.y >= 1) chk($sformatf("row_2(%0d,%0d)", le_e.x, le_e.y), 64'(row_2), 64'(le_e.r2));
        if (le_e.y >= 2) chk($sformatf("row_1(%0d,%0d)", le_e.x, le_e.y), 64'(row_1), 64'(le_e.r1));
      end
    end
    if (win_valid) begin
      win_count++;
      if (win_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL win_unexpected: win_valid=1 at (%0d,%0d) with none pending", win_col, win_row);
      end else begin
        win_e = win_q.pop_front();
        chk("win_col", 64'(win_col), 64'(win_e.col));
        chk("win_row", 64'(win_row), 64'(win_e.row));
        chk($sformatf("frame_done(%0d,%0d)", win_e.col, win_e.row), 64'(frame_done), 64'(win_e.last));
      end
    end else if (frame_done) begin
      checks++; errors++;
      $display("FAIL frame_done_alone: frame_done=1 got, required 0 without win_valid");
    end
    if (frame_done) fd_count++;
  end

  task automatic send_pixel(input int x, input int y, output int waits,
                            output logic le_s, output logic sh_s, output logic wv_s);
    le_exp_t  e;
    win_exp_t w;
    bit       ok;
    ok        = 1'b0;
    waits     = 0;
    pix_in    = DW'(16 * y + x);
    pix_valid = 1'b1;
    le_s = 1'b0; sh_s = 1'b0; wv_s = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (pix_ready) ok = 1'b1;
      else waits++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout(%0d,%0d): pix_ready=0 got, required 1 within 20 cycles", x, y);
      return;
    end
    le_s = LE; sh_s = shift; wv_s = win_valid;
    e.x = x; e.y = y; e.sh = (x >= 1);
    e.r3 = DW'(16 * y + x);
    e.r2 = DW'(16 * (y - 1) + x);
    e.r1 = DW'(16 * (y - 2) + x);
    le_q.push_back(e);
    if (x >= 3 && y >= 2) begin
      w.col = x - 2; w.row = y - 1; w.last = 1'b0;
      win_q.push_back(w);
    end
    if (x == W - 1 && y >= 2) begin
      w.col = W - 2; w.row = y - 1; w.last = (y == H - 1);
      win_q.push_back(w);
    end
    @(posedge clk); #1;
  endtask

  task automatic stall_test();
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_strobes", 64'({LE, shift, win_valid, pix_ready}), 64'd0);
      chk("stall_rows", 64'({row_1, row_2, row_3}), 64'({16'h02, 16'h12, 16'h22}));
    end
    @(posedge clk); #1;
    stall = 1'b0;
  endtask

  task automatic run_frame(input int last_y, input int last_x, input bit do_stall, input int first_waits);
    int   waits;
    logic le_s, sh_s, wv_s;
    for (int y = 0; y <= last_y; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == last_y && x > last_x) break;
        send_pixel(x, y, waits, le_s, sh_s, wv_s);
        if (x == 0 && y == 0 && first_waits >= 0)
          chk("first_pixel_wait", 64'(waits), 64'(first_waits));
        if (x == 0 && y > 0) begin
          chk($sformatf("flush_gap_row%0d", y - 1), 64'(waits), 64'd1);
          chk($sformatf("flush_bubble_row%0d", y - 1), 64'({le_s, sh_s}), 64'b01);
        end
        if (x == 1 && y == 2) chk("flush_no_win_row1", 64'(wv_s), 64'd0);
        if (do_stall && x == 2 && y == 2) stall_test();
      end
    end
  endtask

  initial begin
    rst_in    = 1'b1;
    pix_valid = 1'b1;
    pix_in    = 16'h55;
    stall     = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("reset_ready", 64'(pix_ready), 64'd0);
      chk("reset_outputs",
          64'({row_1, row_2, row_3, LE, shift, win_valid, win_col, win_row, frame_done}), 64'd0);
    end
    rst_in    = 1'b0;
    pix_valid = 1'b0;

    run_frame(H - 1, W - 1, 1'b0, 0);
    run_frame(H - 1, W - 1, 1'b1, 1);
    run_frame(1, 3, 1'b0, 1);

    pix_valid = 1'b0;
    rst_in    = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    chk("midreset_clear", 64'({LE, shift, win_valid, frame_done, row_3}), 64'd0);

    run_frame(H - 1, W - 1, 1'b0, 0);
    pix_valid = 1'b0;

    repeat (10) @(posedge clk);
    #1;
    chk("le_queue_drained", 64'(le_q.size()), 64'd0);
    chk("win_queue_drained", 64'(win_q.size()), 64'd0);
    chk("win_pulse_total", 64'(win_count), 64'(3 * (W - 2) * (H - 2)));
    chk("frame_done_total", 64'(fd_count), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
